// File: rtl/lcd_msg_ctrl.sv
// lcd_msg_ctrl: drives an HD44780-style character LCD over an 8-bit parallel bus.
// After power-on it waits INIT_CYC cycles, issues the init commands 0x38/0x0C/0x01/0x06,
// then idles. Each accepted ready_i rewrites ROWS x COLS characters from an internal ROM
// selected by the latched msg_i.
//
// Optional feature: define LCD_SCORE_EN to show the latched score_i as two decimal digits
// in the last two columns of row 0 (saturating at 99). Without it score_i is unused.
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous active-low reset
//   ready_i  in   refresh request, sampled only while idle
//   msg_i    in   message index, latched on acceptance
//   score_i  in   binary score, latched on acceptance
//   rs/rw/enable out LCD control lines (rw tied low)
//   data     out  LCD data bus
//   busy_o   out  high from acceptance until the refresh completes
//   done_o   out  one-cycle pulse at refresh completion
module lcd_msg_ctrl #(
    parameter int unsigned WAIT_CYC = 25,
    parameter int unsigned INIT_CYC = 750000,
    parameter int unsigned CLR_CYC  = 80000,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 16,
    parameter int unsigned MSG_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready_i,
    input  logic [MSG_W-1:0] msg_i,
    input  logic [7:0]       score_i,
    output logic             rs,
    output logic             rw,
    output logic             enable,
    output logic [7:0]       data,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned WR_LAST = 2 * WAIT_CYC;
    localparam int unsigned PH_W    = $clog2(WR_LAST + 1);
    localparam int unsigned DLY_MAX = (INIT_CYC > CLR_CYC) ? INIT_CYC : CLR_CYC;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

    localparam logic [127:0] M0_R0 = "READY   SCORE 00";
    localparam logic [127:0] M0_R1 = "PRESS START     ";
    localparam logic [127:0] M0_R2 = "MSG ZERO ROW 2  ";
    localparam logic [127:0] M0_R3 = "MSG ZERO ROW 3  ";
    localparam logic [127:0] M1_R0 = "GAME OVER     --";
    localparam logic [127:0] M1_R1 = "PLAYER ONE      ";
    localparam logic [127:0] M1_R2 = "TRY AGAIN       ";
    localparam logic [127:0] M1_R3 = "ABCDEFGHIJKLMNOP";

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_CMD, IDLE, SET_ADDR, WR_CHAR, FINISH
    } state_t;

    state_t           state_q;
    logic [PH_W-1:0]  ph_q;       // position inside the current 1+2*WAIT_CYC bus write
    logic [DLY_W-1:0] dly_q;
    logic [1:0]       cmd_q;
    logic             clr_wait_q;
    logic [1:0]       row_q;
    logic [3:0]       col_q;
    logic [MSG_W-1:0] msg_q;
    logic             wr_done;
    logic [3:0]       char_col;
    logic [7:0]       char_val;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] row_addr(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h90;
            default: return 8'hD0;
        endcase
    endfunction

    // Undefined message indices read back as all spaces.
    function automatic logic [7:0] rom_char(input logic [MSG_W-1:0] m, input logic [1:0] r,
                                            input logic [3:0] c);
        logic [127:0] txt;
        txt = {16{8'h20}};
        if (m == MSG_W'(0)) begin
            case (r)
                2'd0:    txt = M0_R0;
                2'd1:    txt = M0_R1;
                2'd2:    txt = M0_R2;
                default: txt = M0_R3;
            endcase
        end else if (m == MSG_W'(1)) begin
            case (r)
                2'd0:    txt = M1_R0;
                2'd1:    txt = M1_R1;
                2'd2:    txt = M1_R2;
                default: txt = M1_R3;
            endcase
        end
        return txt[{4'd15 - c, 3'b000} +: 8];
    endfunction

    assign wr_done = (ph_q == PH_W'(WR_LAST));
    assign rw      = 1'b0;

`ifdef LCD_SCORE_EN
    logic [7:0] score_q;
    logic [6:0] score_sat;
    logic [6:0] tens;
    logic [6:0] ones;

    assign score_sat = (score_q > 8'd99) ? 7'd99 : score_q[6:0];
    assign tens      = score_sat / 7'd10;
    assign ones      = score_sat % 7'd10;
`else
    logic score_unused;
    assign score_unused = ^score_i;
`endif

    // Character for the write that follows the current one: column 0 after an address
    // write, otherwise the next column of the current row.
    always_comb begin
        char_col = (state_q == WR_CHAR) ? col_q + 4'd1 : 4'd0;
        char_val = rom_char(msg_q, row_q, char_col);
`ifdef LCD_SCORE_EN
        if (row_q == 2'd0 && char_col == 4'(COLS - 2)) begin
            char_val = 8'h30 + {1'b0, tens};
        end else if (row_q == 2'd0 && char_col == 4'(COLS - 1)) begin
            char_val = 8'h30 + {1'b0, ones};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PWR_WAIT;
            ph_q       <= '0;
            dly_q      <= '0;
            cmd_q      <= 2'd0;
            clr_wait_q <= 1'b0;
            row_q      <= 2'd0;
            col_q      <= 4'd0;
            msg_q      <= '0;
`ifdef LCD_SCORE_EN
            score_q    <= 8'd0;
`endif
            rs         <= 1'b0;
            enable     <= 1'b0;
            data       <= 8'h00;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            // Common write engine: setup cycle, WAIT_CYC high, WAIT_CYC low.
            if ((state_q == INIT_CMD && !clr_wait_q) || state_q == SET_ADDR
                    || state_q == WR_CHAR) begin
                if (!wr_done) begin
                    ph_q   <= ph_q + 1'b1;
                    enable <= (ph_q < PH_W'(WAIT_CYC));
                end else begin
                    ph_q <= '0;
                end
            end
            case (state_q)
                PWR_WAIT: begin
                    if (dly_q == DLY_W'(INIT_CYC - 1)) begin
                        dly_q   <= '0;
                        cmd_q   <= 2'd0;
                        rs      <= 1'b0;
                        data    <= init_cmd(2'd0);
                        state_q <= INIT_CMD;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                INIT_CMD: begin
                    if (clr_wait_q) begin
                        if (dly_q == DLY_W'(CLR_CYC - 1)) begin
                            clr_wait_q <= 1'b0;
                            dly_q      <= '0;
                            cmd_q      <= 2'd3;
                            data       <= init_cmd(2'd3);
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end else if (wr_done) begin
                        if (cmd_q == 2'd2) begin
                            clr_wait_q <= 1'b1;
                        end else if (cmd_q == 2'd3) begin
                            state_q <= IDLE;
                        end else begin
                            cmd_q <= cmd_q + 2'd1;
                            data  <= init_cmd(cmd_q + 2'd1);
                        end
                    end
                end
                IDLE: begin
                    if (ready_i) begin
                        msg_q   <= msg_i;
`ifdef LCD_SCORE_EN
                        score_q <= score_i;
`endif
                        busy_o  <= 1'b1;
                        row_q   <= 2'd0;
                        col_q   <= 4'd0;
                        rs      <= 1'b0;
                        data    <= row_addr(2'd0);
                        state_q <= SET_ADDR;
                    end
                end
                SET_ADDR: begin
                    if (wr_done) begin
                        col_q   <= 4'd0;
                        rs      <= 1'b1;
                        data    <= char_val;
                        state_q <= WR_CHAR;
                    end
                end
                WR_CHAR: begin
                    if (wr_done) begin
                        if (col_q == 4'(COLS - 1)) begin
                            if (row_q == 2'(ROWS - 1)) begin
                                done_o  <= 1'b1;
                                busy_o  <= 1'b0;
                                state_q <= FINISH;
                            end else begin
                                row_q   <= row_q + 2'd1;
                                rs      <= 1'b0;
                                data    <= row_addr(row_q + 2'd1);
                                state_q <= SET_ADDR;
                            end
                        end else begin
                            col_q <= col_q + 4'd1;
                            data  <= char_val;
                        end
                    end
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
module tb_lcd_msg_ctrl;

    localparam int WAIT = 2;
    localparam int COLS = 16;
    localparam int ROWS = 4;
    localparam int REFRESH = ROWS * (1 + COLS) * (1 + 2 * WAIT);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ready;
    logic [2:0] msg;
    logic [7:0] score;
    logic       rs, rw, en, busy, done;
    logic [7:0] data;

    lcd_msg_ctrl #(
        .WAIT_CYC(2), .INIT_CYC(10), .CLR_CYC(20), .ROWS(4), .COLS(16), .MSG_W(3)
    ) dut (
        .clk(clk), .reset(rst_n), .ready_i(ready), .msg_i(msg), .score_i(score),
        .rs(rs), .rw(rw), .enable(en), .data(data), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_q[$];
    int rise_q[$];
    int n_cmp = 0, n_err = 0;
    int n_writes = 0, done_cnt = 0;
    int busy_rise_cyc = -1, last_done_cyc = -1, restart_gap = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic string rom_line(input int m, input int r);
        if (m == 0) begin
            case (r)
                0: return "READY   SCORE 00";
                1: return "PRESS START     ";
                2: return "MSG ZERO ROW 2  ";
                default: return "MSG ZERO ROW 3  ";
            endcase
        end else if (m == 1) begin
            case (r)
                0: return "GAME OVER     --";
                1: return "PLAYER ONE      ";
                2: return "TRY AGAIN       ";
                default: return "ABCDEFGHIJKLMNOP";
            endcase
        end
        return "                ";
    endfunction

    function automatic logic [7:0] exp_char(input int m, input int r, input int c, input int sc);
        string s;
        logic [7:0] b;
        int sat;
        s = rom_line(m, r);
        b = s[c];
        sat = (sc > 99) ? 99 : sc;
`ifdef LCD_SCORE_EN
        if (r == 0 && c == COLS - 2) b = 8'(48 + sat / 10);
        if (r == 0 && c == COLS - 1) b = 8'(48 + sat % 10);
`endif
        return b;
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_refresh(input int m, input int sc);
        logic [7:0] addr [4];
        addr[0] = 8'h80; addr[1] = 8'hC0; addr[2] = 8'h90; addr[3] = 8'hD0;
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b0, addr[r]});
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, exp_char(m, r, c, sc)});
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int k = 0;
        while (exp_q.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_done(input int target, input int max);
        int k = 0;
        while (done_cnt < target && k < max) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt, target);
    endtask

    task automatic check_init_timing();
        check("init_write_count", rise_q.size(), 4);
        if (rise_q.size() == 4) begin
            check("gap_38_0c", rise_q[1] - rise_q[0], 1 + 2 * WAIT);
            check("gap_0c_01", rise_q[2] - rise_q[1], 1 + 2 * WAIT);
            check("gap_01_06", rise_q[3] - rise_q[2], 1 + 2 * WAIT + 20);
        end
    endtask

    // Monitor: pops the scoreboard on each enable rise and checks pulse shape and timing.
    initial begin
        logic en_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
        int hi_cnt = 0;
        logic [8:0] cap = '0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 1'b0; busy_prev = 1'b0; done_prev = 1'b0; hi_cnt = 0;
                continue;
            end
            if (en && !en_prev) begin
                n_writes++;
                rise_q.push_back(cyc);
                cap = {rs, data};
                check("rw_low", rw, 0);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got rs=%0d data=0x%0h expected none",
                             rs, data);
                end else begin
                    e = exp_q.pop_front();
                    if (cap != e) begin
                        n_err++;
                        $display("FAIL bus_write: got rs=%0d data=0x%0h expected rs=%0d data=0x%0h",
                                 cap[8], cap[7:0], e[8], e[7:0]);
                    end
                end
                hi_cnt = 1;
            end else if (en) begin
                hi_cnt++;
            end
            if (!en && en_prev) begin
                check("enable_width", hi_cnt, WAIT);
                check("bus_stable", {rs, data}, cap);
            end
            if (busy && !busy_prev) begin
                busy_rise_cyc = cyc;
                if (last_done_cyc >= 0) restart_gap = cyc - last_done_cyc;
            end
            if (done) begin
                check("done_latency", cyc - busy_rise_cyc, REFRESH);
                check("busy_clear_at_done", busy, 0);
                check("done_single_cycle", done_prev, 0);
                last_done_cyc = cyc;
                done_cnt++;
            end
            en_prev = en; busy_prev = busy; done_prev = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, base, k;
        rst_n = 1'b0; ready = 1'b0; msg = 3'd0; score = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rs", rs, 0);
        check("rst_rw", rw, 0);
        check("rst_enable", en, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Power-on and init; a ready pulse during init must be ignored.
        push_init();
        rise_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        wait_drain("init_drain", 200);
        check_init_timing();
        repeat (8) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("no_write_from_early_ready", n_writes, 4);

        // msg 1, score 7; mid-refresh ready pulse and input changes must not matter.
        push_refresh(1, 7);
        dc = done_cnt;
        msg = 3'd1; score = 8'd7; ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        repeat (60) @(posedge clk);
        #1 ready = 1'b1; msg = 3'd2; score = 8'd99;
        @(posedge clk); #1 ready = 1'b0; msg = 3'd3; score = 8'd55;
        wait_done(dc + 1, 1000);
        repeat (10) @(posedge clk);
        #1;
        check("no_restart_busy", busy, 0);
        check("refresh1_drain", exp_q.size(), 0);

        // msg 0 with saturating score.
        push_refresh(0, 150);
        dc = done_cnt;
        msg = 3'd0; score = 8'd150; ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        wait_done(dc + 1, 1000);
        check("refresh2_drain", exp_q.size(), 0);

        // Undefined message index: all spaces.
        repeat (3) @(posedge clk);
        push_refresh(5, 42);
        dc = done_cnt;
        #1 msg = 3'd5; score = 8'd42; ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        wait_done(dc + 1, 1000);
        check("refresh3_drain", exp_q.size(), 0);

        // ready held high: back-to-back refreshes.
        repeat (3) @(posedge clk);
        push_refresh(1, 99);
        push_refresh(1, 99);
        dc = done_cnt;
        restart_gap = -1;
        #1 msg = 3'd1; score = 8'd99; ready = 1'b1;
        wait_done(dc + 1, 1000);
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("held_ready_restart", busy, 1);
        @(posedge clk); #1 ready = 1'b0;
        check("restart_gap", restart_gap, 2);
        wait_done(dc + 2, 1000);
        repeat (10) @(posedge clk);
        #1;
        check("held_ready_stop", busy, 0);
        check("refresh4_drain", exp_q.size(), 0);

        // Reset while enable is high in row 2.
        push_refresh(1, 0);
        base = n_writes;
        msg = 3'd1; score = 8'd0; ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        k = 0;
        while (n_writes < base + 36 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("reached_row2", n_writes, base + 36);
        @(posedge clk); #1;
        check("enable_before_reset", en, 1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_enable", en, 0);
        check("reset_drops_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        push_init();
        rise_q.delete();
        #1 rst_n = 1'b1;
        wait_drain("reinit_drain", 200);
        check_init_timing();
        repeat (8) @(posedge clk);
        #1 check("reinit_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
